// File: rtl/cpu_clock_controller.sv
// Core clock-enable sequencer: divided RUN, single-STEP from button, HALTED; counts issued enables.
// Optional breakpoint halt when CLKCTRL_BREAK_EN is defined (adds the break_at port).
module cpu_clock_controller #(
  parameter int RATIO = 10,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic             resume,
`ifdef CLKCTRL_BREAK_EN
  input  logic [CNT_W-1:0] break_at,
`endif
  output logic             cpu_en,
  output logic [CNT_W-1:0] tick_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  localparam int               DIV_W   = $clog2(RATIO + 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RATIO);

  state_t           st;
  logic [DIV_W-1:0] div_cnt;
  logic             step_q;
  logic             resume_q;
  logic             step_edge;
  logic             resume_edge;
  logic             brk_hit;
  logic [CNT_W-1:0] tick_nxt;

  assign step_edge   = step_btn & ~step_q;
  assign resume_edge = resume & ~resume_q;
  assign tick_nxt    = tick_cnt + CNT_W'(1);
  assign state       = st;

`ifdef CLKCTRL_BREAK_EN
  // Compare against the post-increment count so the breakpoint pulse itself is delivered.
  assign brk_hit = (break_at != '0) && (tick_nxt == break_at);
`else
  assign brk_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      cpu_en   <= 1'b0;
      tick_cnt <= '0;
      div_cnt  <= DIV_ONE;
      step_q   <= 1'b1;
      resume_q <= 1'b1;
    end else begin
      step_q   <= step_btn;
      resume_q <= resume;
      cpu_en   <= 1'b0;
      case (st)
        IDLE: begin
          div_cnt <= DIV_ONE;
          if (halt_req)    st <= HALTED;
          else if (run_sw) st <= RUN;
          else             st <= STEP;
        end
        RUN: begin
          if (halt_req) begin
            st <= HALTED;
          end else if (!run_sw) begin
            st      <= STEP;
            div_cnt <= DIV_ONE;
          end else if (div_cnt == DIV_MAX) begin
            cpu_en   <= 1'b1;
            div_cnt  <= DIV_ONE;
            tick_cnt <= tick_nxt;
            if (brk_hit) st <= HALTED;
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
        STEP: begin
          if (halt_req) begin
            st <= HALTED;
          end else if (run_sw) begin
            st      <= RUN;
            div_cnt <= DIV_ONE;
          end else if (step_edge) begin
            cpu_en   <= 1'b1;
            tick_cnt <= tick_nxt;
            if (brk_hit) st <= HALTED;
          end
        end
        HALTED: begin
          if (resume_edge) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Self-checking bench for cpu_clock_controller: directed scenarios plus randomized run against a reference model.
module tb_cpu_clock_controller;
  localparam int RATIO = 10;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             run_sw;
  logic             step_btn;
  logic             halt_req;
  logic             resume;
  logic [CNT_W-1:0] brk;
  logic             cpu_en;
  logic [CNT_W-1:0] tick_cnt;
  logic [1:0]       state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode as a plain int, run timing as cycles since RUN entry.
  int               m_state = 0;
  int               m_age = 0;
  logic [CNT_W-1:0] m_tick = '0;
  logic             m_en = 1'b0;
  logic             m_pbtn = 1'b1;
  logic             m_pres = 1'b1;

  cpu_clock_controller #(.RATIO(RATIO), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .halt_req (halt_req),
    .resume   (resume),
`ifdef CLKCTRL_BREAK_EN
    .break_at (brk),
`endif
    .cpu_en   (cpu_en),
    .tick_cnt (tick_cnt),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic step_clk();
    logic pulse;
    @(posedge clk);
    pulse = 1'b0;
    if (!rst_n) begin
      m_state = 0; m_age = 0; m_tick = '0; m_pbtn = 1'b1; m_pres = 1'b1;
    end else begin
      case (m_state)
        0: begin
          m_age = 0;
          m_state = halt_req ? 3 : (run_sw ? 1 : 2);
        end
        1: begin
          if (halt_req) m_state = 3;
          else if (!run_sw) m_state = 2;
          else begin
            m_age++;
            pulse = ((m_age % RATIO) == 0);
          end
        end
        2: begin
          if (halt_req) m_state = 3;
          else if (run_sw) begin m_state = 1; m_age = 0; end
          else pulse = step_btn && !m_pbtn;
        end
        default: if (resume && !m_pres) m_state = 0;
      endcase
      if (pulse) begin
        m_tick++;
`ifdef CLKCTRL_BREAK_EN
        if (brk != '0 && m_tick == brk) m_state = 3;
`endif
      end
      m_pbtn = step_btn;
      m_pres = resume;
    end
    m_en = pulse;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run_sw = 1'b1; step_btn = 1'b0; halt_req = 1'b0; resume = 1'b0; brk = '0;
    step_clk(); step_clk();
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b want 00", state); end
    n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", cpu_en); end
    n_cmp++; if (tick_cnt !== '0) begin n_err++; $display("FAIL reset_tick: got %0d want 0", tick_cnt); end
    rst_n = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      logic exp_en;
      step_clk();
      exp_en = (e == 11 || e == 21 || e == 31);
      n_cmp++; if (cpu_en !== exp_en) begin n_err++; $display("FAIL run_pulse e%0d: got %b want %b", e, cpu_en, exp_en); end
      n_cmp++; if (state !== 2'b01) begin n_err++; $display("FAIL run_state e%0d: got %b want 01", e, state); end
      if (e == 31) begin
        n_cmp++; if (tick_cnt !== 32'd3) begin n_err++; $display("FAIL run_tick: got %0d want 3", tick_cnt); end
      end
    end
  endtask

  task automatic test_step();
    logic [CNT_W-1:0] base;
    int pulses;
    run_sw = 1'b0;
    step_clk();
    n_cmp++; if (state !== 2'b10) begin n_err++; $display("FAIL step_enter: got %b want 10", state); end
    n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL step_enter_en: got %b want 0", cpu_en); end
    base = m_tick;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      int hold;
      int gap;
      hold = (k == 1) ? 20 : int'($urandom_range(1, 4));
      gap = int'($urandom_range(2, 5));
      step_btn = 1'b1;
      for (int c = 0; c < hold; c++) begin
        step_clk();
        if (cpu_en === 1'b1) pulses++;
        n_cmp++; if (cpu_en !== (c == 0)) begin n_err++; $display("FAIL step_hold k%0d c%0d: got %b want %b", k, c, cpu_en, (c == 0)); end
      end
      step_btn = 1'b0;
      for (int c = 0; c < gap; c++) begin
        step_clk();
        if (cpu_en === 1'b1) pulses++;
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL step_gap k%0d: got %b want 0", k, cpu_en); end
      end
    end
    n_cmp++; if (pulses != 3) begin n_err++; $display("FAIL step_count: got %0d want 3", pulses); end
    n_cmp++; if (tick_cnt !== base + 32'd3) begin n_err++; $display("FAIL step_tick: got %0d want %0d", tick_cnt, base + 32'd3); end
  endtask

  task automatic test_halt_pulse();
    logic [CNT_W-1:0] base;
    bit found;
    rst_n = 1'b0; run_sw = 1'b1; step_btn = 1'b0; halt_req = 1'b0; resume = 1'b0;
    step_clk();
    rst_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 4 * RATIO; c++) begin
      step_clk();
      if (m_state == 1 && c > RATIO && ((m_age + 1) % RATIO) == 0) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL halt_setup: got no due pulse want one within budget"); end
    base = m_tick;
    halt_req = 1'b1;
    step_clk();
    n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL halt_en: got %b want 0", cpu_en); end
    n_cmp++; if (state !== 2'b11) begin n_err++; $display("FAIL halt_state: got %b want 11", state); end
    n_cmp++; if (tick_cnt !== base) begin n_err++; $display("FAIL halt_tick: got %0d want %0d", tick_cnt, base); end
  endtask

  task automatic test_resume();
    run_sw = 1'b0;
    resume = 1'b1;
    step_clk();
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL resume_held_idle: got %b want 00", state); end
    step_clk();
    n_cmp++; if (state !== 2'b11) begin n_err++; $display("FAIL resume_rehalt: got %b want 11", state); end
    resume = 1'b0; halt_req = 1'b0;
    step_clk();
    n_cmp++; if (state !== 2'b11) begin n_err++; $display("FAIL resume_stay: got %b want 11", state); end
    resume = 1'b1;
    step_clk();
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL resume_idle: got %b want 00", state); end
    step_clk();
    n_cmp++; if (state !== 2'b10) begin n_err++; $display("FAIL resume_step: got %b want 10", state); end
    resume = 1'b0;
  endtask

  task automatic test_btn_through_reset();
    rst_n = 1'b0; run_sw = 1'b0; step_btn = 1'b1; halt_req = 1'b0; resume = 1'b0;
    step_clk(); step_clk();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step_clk();
      n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL held_btn c%0d: got %b want 0", c, cpu_en); end
    end
    step_btn = 1'b0;
    step_clk();
    step_btn = 1'b1;
    step_clk();
    n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL first_edge: got %b want 1", cpu_en); end
    step_clk();
    n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL first_edge_len: got %b want 0", cpu_en); end
    n_cmp++; if (tick_cnt !== 32'd1) begin n_err++; $display("FAIL first_edge_tick: got %0d want 1", tick_cnt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 39) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 7) == 0) resume = ~resume;
      if (halt_req) halt_req = ($urandom_range(0, 2) != 0);
      else halt_req = ($urandom_range(0, 59) == 0);
      step_clk();
      n_cmp++; if (state !== 2'(m_state)) begin n_err++; $display("FAIL rand_state c%0d: got %b want %0d", c, state, m_state); end
      n_cmp++; if (cpu_en !== m_en) begin n_err++; $display("FAIL rand_en c%0d: got %b want %b", c, cpu_en, m_en); end
      n_cmp++; if (tick_cnt !== m_tick) begin n_err++; $display("FAIL rand_tick c%0d: got %0d want %0d", c, tick_cnt, m_tick); end
    end
  endtask

`ifdef CLKCTRL_BREAK_EN
  task automatic test_break();
    rst_n = 1'b0; run_sw = 1'b1; step_btn = 1'b0; halt_req = 1'b0; resume = 1'b0; brk = 32'd5;
    step_clk();
    rst_n = 1'b1;
    for (int c = 0; c < 70; c++) step_clk();
    n_cmp++; if (state !== 2'b11) begin n_err++; $display("FAIL brk_state: got %b want 11", state); end
    n_cmp++; if (tick_cnt !== 32'd5) begin n_err++; $display("FAIL brk_tick: got %0d want 5", tick_cnt); end
    rst_n = 1'b0; brk = '0;
    step_clk();
    rst_n = 1'b1;
    for (int c = 0; c < 70; c++) step_clk();
    n_cmp++; if (state !== 2'b01) begin n_err++; $display("FAIL brk_off_state: got %b want 01", state); end
    n_cmp++; if (tick_cnt !== 32'd6) begin n_err++; $display("FAIL brk_off_tick: got %0d want 6", tick_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_step();
    test_halt_pulse();
    test_resume();
    test_btn_through_reset();
    test_random();
`ifdef CLKCTRL_BREAK_EN
    test_break();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_clock_controller.md
# cpu_clock_controller

Sequences the processor core's clock enable on the FPGA board. Selects free-running divided execution, single-step execution from a debounced push button, or a halted state, and reports a count of issued enables for the display. It owns the run-mode divide counter, so the core runs on `clk` gated by a single-cycle `cpu_en`, never on a derived clock.

## Interface
- `RATIO`, 10: run-mode divide ratio; one `cpu_en` pulse every `RATIO` clk cycles; legal range ≥ 2.
- `CNT_W`, 32: width of `tick_cnt` and `break_at`.
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `run_sw` in 1: level; 1 selects RUN, 0 selects STEP.
- `step_btn` in 1: debounced, clk-synchronous button; each rising edge requests one step.
- `halt_req` in 1: level from the core (halt instruction); forces HALTED.
- `resume` in 1: rising edge leaves HALTED.
- `break_at` in `CNT_W`: breakpoint tick count. Present only with `CLKCTRL_BREAK_EN`.
- `cpu_en` out 1: core clock enable; one-cycle pulses only.
- `tick_cnt` out `CNT_W`: total `cpu_en` pulses issued since reset.
- `state` out 2: IDLE=00, RUN=01, STEP=10, HALTED=11.

## Operation
- All outputs are registered.
- Reset values: `state`=IDLE, `cpu_en`=0, `tick_cnt`=0, `div_cnt`=1.
- Edge detectors `step_q` and `resume_q` reset to 1, so a button held through reset produces no edge.
- Edges:
  - step edge = `step_btn & ~step_q`.
  - resume edge = `resume & ~resume_q`.
- IDLE: next cycle goes to RUN if `run_sw`=1, otherwise to STEP; `div_cnt` is set to 1.
- RUN:
  - if `div_cnt`==`RATIO`: set `cpu_en`=1 and `div_cnt`=1;
  - otherwise: set `cpu_en`=0 and increment `div_cnt`.
- RUN → STEP when `run_sw`=0: no pulse in that cycle; `div_cnt` is set to 1.
- STEP: each step edge sets `cpu_en`=1 for exactly one cycle. A held button gives one pulse. Step edges in RUN, IDLE or HALTED are discarded, not queued.
- STEP → RUN when `run_sw`=1, with `div_cnt`=1.
- `halt_req`=1 in RUN or STEP:
  - next state is HALTED;
  - overrides any pulse due in the same cycle (`cpu_en`=0, `tick_cnt` unchanged).
- HALTED:
  - `cpu_en`=0;
  - a resume edge goes to IDLE;
  - if `halt_req` is still 1 in IDLE, the block returns to HALTED on the next cycle.
- Priority, highest first: `rst_n`, `halt_req`, mode change (`run_sw`), pulse generation.
- `tick_cnt` increments on the same edge that sets `cpu_en`=1 and wraps modulo 2^`CNT_W` with no flag.

## Timing
- RUN entered at edge T: first `cpu_en` is high during cycle T+`RATIO`; steady period is `RATIO` cycles, duty 1/`RATIO`.
- STEP: `step_btn` rises before edge T → `cpu_en` is high during the cycle after T (1-cycle latency).
- `halt_req` sampled at edge T → `state`=HALTED and `cpu_en`=0 after T.
- Resume edge sampled at T → IDLE after T; RUN or STEP after T+1.
- Reset mid-pulse: `cpu_en` clears on the reset edge; the counter restarts at 1.

## Configuration
- Macro: `CLKCTRL_BREAK_EN`.
- Defined:
  - the `break_at` port exists;
  - when a pulse is issued and `tick_cnt`+1 == `break_at`, that pulse is delivered and `state` becomes HALTED on the same edge;
  - `break_at`=0 disables the breakpoint;
  - resume behaves as after a `halt_req` halt.
- Undefined: no `break_at` port and no comparator; only `halt_req` halts.

## Test plan
- Reset with `run_sw`=1, `RATIO`=10, release at edge 0 → `state`=RUN at edge 1; `cpu_en` high in cycles 11, 21, 31; `tick_cnt`=3 after cycle 31.
- `run_sw`=0, three `step_btn` rising edges (one held 20 cycles) → exactly three one-cycle `cpu_en` pulses, each one cycle after its edge; `tick_cnt`=3.
- RUN, `halt_req` asserted in the cycle a pulse is due → no pulse; `state`=HALTED; `tick_cnt` unchanged.
- HALTED, `halt_req` held, resume edge → IDLE then HALTED again. Drop `halt_req`, give a resume edge → IDLE, then RUN or STEP per `run_sw`.
- `step_btn` held through reset and release → no pulse; the first subsequent rising edge gives exactly one pulse.
- With `CLKCTRL_BREAK_EN`, `break_at`=5, RUN → the 5th pulse is issued, then `state`=HALTED with `tick_cnt`=5. With `break_at`=0, pulses continue past 5.
